// File: rtl/acc_seq_fsm.sv
// acc_seq_fsm: sequences one 10-term accumulation from a single-port SRAM.
// Issues reads k=0..9 at P_BASE+k, then drives the matching term select one
// cycle later (SRAM read latency), then pulses oOutValid.
// Optional feature: define ACC_SEQ_PEND_EN to queue one start request that
// arrives while busy; without it such requests are dropped.
// Ports:
//   iClk      rising-edge clock
//   iRsn      asynchronous active-low reset
//   iStart    one-cycle request to run one accumulation
//   iClrOvr   clears oOverrun
//   oRdEn     SRAM read enable
//   oRdAddr   SRAM read address (P_AW bits)
//   oInSel    accumulator term select 0..9
//   oEnDelay  oInSel carries a valid term
//   oOutValid one-cycle pulse: accumulator result valid
//   oBusy     FSM not in IDLE
//   oOverrun  sticky: a start request was dropped
module acc_seq_fsm #(
    parameter int P_AW   = 4,
    parameter int P_BASE = 0
) (
    input  logic            iClk,
    input  logic            iRsn,
    input  logic            iStart,
    input  logic            iClrOvr,
    output logic            oRdEn,
    output logic [P_AW-1:0] oRdAddr,
    output logic [3:0]      oInSel,
    output logic            oEnDelay,
    output logic            oOutValid,
    output logic            oBusy,
    output logic            oOverrun
);

    localparam logic [P_AW-1:0] LP_BASE = P_AW'(P_BASE);
    localparam logic [3:0]      LP_LAST = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic            rden_q, rden_d;
    logic [P_AW-1:0] addr_q, addr_d;
    logic [3:0]      sel_q, sel_d;
    logic            en_q, en_d;
    logic            outv_q, outv_d;
    logic            busy_q, busy_d;
    logic            ovr_q, ovr_d;
    logic            busy;
    logic            drop;
    logic            go;

`ifdef ACC_SEQ_PEND_EN
    logic            pend_q, pend_d;
`endif

    assign busy = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drop    = 1'b0;
`ifdef ACC_SEQ_PEND_EN
        pend_d  = pend_q;
        go      = iStart | pend_q;
`else
        go      = iStart;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_RUN;
                    k_d     = 4'd0;
                end
            end
            S_RUN: begin
                if (k_q == LP_LAST) begin
                    state_d = S_LAST;
                    k_d     = 4'd0;
                end else begin
                    k_d = 4'(k_q + 4'd1);
                end
            end
            S_LAST: begin
                state_d = S_DONE;
            end
            S_DONE: begin
`ifdef ACC_SEQ_PEND_EN
                if (pend_q) begin
                    state_d = S_RUN;
                    k_d     = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 4'd0;
            end
        endcase

`ifdef ACC_SEQ_PEND_EN
        // The queued request is consumed by the run it launches.
        if (state_d == S_RUN && state_q != S_RUN) begin
            pend_d = 1'b0;
        end
        // A request seen while one is already queued (even in IDLE,
        // where the queued one wins the launch) has nowhere to go.
        if (iStart) begin
            if (pend_q) begin
                drop = 1'b1;
            end else if (busy) begin
                pend_d = 1'b1;
            end
        end
`else
        drop = iStart & busy;
`endif

        // Set has priority over clear.
        ovr_d = drop | (ovr_q & ~iClrOvr);

        // Outputs are registered, so they are derived from the next state.
        // The term select trails the read by one cycle: it shows the k
        // that was read in the cycle now ending.
        rden_d = (state_d == S_RUN);
        addr_d = rden_d ? 
                 P_AW'(LP_BASE + P_AW'(k_d)) : LP_BASE;
        en_d   = (state_q == S_RUN);
        sel_d  = en_d ? k_q : 4'd0;
        outv_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
            rden_q  <= 1'b0;
            addr_q  <= LP_BASE;
            sel_q   <= 4'd0;
            en_q    <= 1'b0;
            outv_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rden_q  <= rden_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            outv_q  <= outv_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef ACC_SEQ_PEND_EN
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    assign oRdEn     = rden_q;
    assign oRdAddr   = addr_q;
    assign oInSel    = sel_q;
    assign oEnDelay  = en_q;
    assign oOutValid = outv_q;
    assign oBusy     = busy_q;
    assign oOverrun  = ovr_q;

endmodule

// File: tb/tb_acc_seq_fsm.sv
// tb_acc_seq_fsm: directed bench for acc_seq_fsm with P_BASE=4'hC.
// Each accepted start queues its 12 expected output cycles.
module tb_acc_seq_fsm;

    localparam int         AW   = 4;
    localparam logic [3:0] BASE = 4'hC;

    logic          iClk;
    logic          iRsn;
    logic          iStart;
    logic          iClrOvr;
    logic          oRdEn;
    logic [AW-1:0] oRdAddr;
    logic [3:0]    oInSel;
    logic          oEnDelay;
    logic          oOutValid;
    logic          oBusy;
    logic          oOverrun;

    acc_seq_fsm #(
        .P_AW  (AW),
        .P_BASE(12)
    ) dut (
        .iClk     (iClk),
        .iRsn     (iRsn),
        .iStart   (iStart),
        .iClrOvr  (iClrOvr),
        .oRdEn    (oRdEn),
        .oRdAddr  (oRdAddr),
        .oInSel   (oInSel),
        .oEnDelay (oEnDelay),
        .oOutValid(oOutValid),
        .oBusy    (oBusy),
        .oOverrun (oOverrun)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // {rden, addr[3:0], sel[3:0], en, outv, busy, ovr}
    logic [12:0] q[$];
    int          errors = 0;
    int          checks = 0;
    logic        exp_ovr = 1'b0;

    // Expected outputs in cycle c (1..12) after the start edge.
    function automatic logic [12:0] run_vec(input int c);
        logic       rd, en, ov;
        logic [3:0] a, s;
        rd = 1'b0;
        a  = BASE;
        s  = 4'd0;
        en = 1'b0;
        ov = 1'b0;
        if (c <= 10) begin
            rd = 1'b1;
            a  = BASE + 4'(c - 1);
            if (c >= 2) begin
                s  = 4'(c - 2);
                en = 1'b1;
            end
        end else if (c == 11) begin
            s  = 4'd9;
            en = 1'b1;
        end else begin
            ov = 1'b1;
        end
        return {rd, a, s, en, ov, 1'b1, 1'b0};
    endfunction

    task automatic check(input string tag);
        logic [12:0] e, o;
        if (q.size() > 0) e = q.pop_front();
        else e = {1'b0, BASE, 4'd0, 4'b0000};
        e[0] = exp_ovr;
        o = {oRdEn, oRdAddr, oInSel, oEnDelay,
             oOutValid, oBusy, oOverrun};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drive one cycle of inputs, then check the cycle after the edge.
    task automatic tick(input logic st, input logic clr,
                        input logic acc, input logic drop,
                        input string tag);
        iStart  = st;
        iClrOvr = clr;
        if (acc) begin
            for (int c = 1; c <= 12; c++) q.push_back(run_vec(c));
        end
        if (drop) exp_ovr = 1'b1;
        else if (clr) exp_ovr = 1'b0;
        @(posedge iClk);
        #1;
        iStart  = 1'b0;
        iClrOvr = 1'b0;
        check(tag);
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        iRsn    = 1'b0;
        iStart  = 1'b0;
        iClrOvr = 1'b0;
        #12;
        check("reset");
        iRsn = 1'b1;

        // Single run, accepted on the first edge after reset release.
        tick(1'b1, 1'b0, 1'b1, 1'b0, "run1_start");
        drain(14, "run1");

        // Start request in cycle 5 of a run.
        tick(1'b1, 1'b0, 1'b1, 1'b0, "ovr_start");
        drain(4, "ovr_pre");
`ifdef ACC_SEQ_PEND_EN
        tick(1'b1, 1'b0, 1'b1, 1'b0, "pend_set");
        drain(9, "pend_b2b");
        tick(1'b1, 1'b0, 1'b1, 1'b0, "pend_set2");
        tick(1'b1, 1'b0, 1'b0, 1'b1, "pend_drop");
        drain(30, "pend_drain");
`else
        tick(1'b1, 1'b0, 1'b0, 1'b1, "ovr_drop");
        drain(9, "ovr_post");
`endif
        tick(1'b0, 1'b1, 1'b0, 1'b0, "ovr_clr");
        drain(2, "idle");

        // Clear and dropped start on the same edge: set wins.
        tick(1'b1, 1'b0, 1'b1, 1'b0, "race_start");
        drain(2, "race_pre");
`ifdef ACC_SEQ_PEND_EN
        tick(1'b1, 1'b0, 1'b1, 1'b0, "race_pend");
`endif
        tick(1'b1, 1'b1, 1'b0, 1'b1, "race_clr_drop");
        drain(30, "race_drain");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "race_clr");

        // Asynchronous reset in cycle 7 of a run.
        tick(1'b1, 1'b0, 1'b1, 1'b0, "arst_start");
        drain(6, "arst_pre");
        #2;
        iRsn = 1'b0;
        #1;
        q.delete();
        exp_ovr = 1'b0;
        check("arst_async");
        @(posedge iClk);
        #1;
        check("arst_hold");
        iRsn = 1'b1;
        tick(1'b1, 1'b0, 1'b1, 1'b0, "arst_restart");
        drain(14, "arst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
